// File: rtl/nids_pkg.sv
// Shared NIDS definitions: datapath widths, hit record layout, reporter FSM
// states and a lowest-set-bit helper used by the match reporter.
package nids_pkg;

  localparam int PV_W      = 32;
  localparam int ST_W      = 10;
  localparam int OFF_W     = 16;
  localparam int RID_W     = 5;
  localparam int HIT_DEPTH = 4;

  typedef struct packed {
    logic [PV_W-1:0]  pv;
    logic [OFF_W-1:0] off;
  } hit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } rep_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [RID_W-1:0] lowest_bit(input logic [PV_W-1:0] v);
    lowest_bit = '0;
    for (int i = PV_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = RID_W'(i);
    end
  endfunction

endpackage

// File: rtl/match_reporter_if.sv
// Rule-event output channel of the match reporter (valid/ready).
//   valid  : event available
//   ready  : consumer accepts the event
//   rule   : matched rule index
//   offset : packet byte offset of the final byte
interface match_if;
  import nids_pkg::*;

  logic             valid;
  logic             ready;
  logic [RID_W-1:0] rule;
  logic [OFF_W-1:0] offset;

  modport master (output valid, output rule, output offset, input ready);
  modport slave  (input valid, input rule, input offset, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO for hit records.
//   clk, reset       : clock, synchronous active-high reset
//   push, wr_data    : write request (ignored when full)
//   pop, rd_data     : read request; rd_data shows the head entry
//   full, empty      : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/match_reporter.sv
// Match reporter: ANDs path vectors across a packet, queues hits reached on
// accepting states, and emits each set rule bit as a {rule, offset} event.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, pkt_start : lookup result valid / first byte of a packet
//   in_state            : next state (informational only)
//   in_path, in_final   : path vector and accepting flag
//   m                   : rule-event channel (match_if master)
//   drop_flag, drop_cnt : sticky loss flag and saturating loss count
module match_reporter
  import nids_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             pkt_start,
  input  logic [ST_W-1:0]  in_state,
  input  logic [PV_W-1:0]  in_path,
  input  logic             in_final,
  match_if.master          m,
  output logic             drop_flag,
  output logic [7:0]       drop_cnt
);
  logic [PV_W-1:0]  acc;
  logic [OFF_W-1:0] offset;
  logic [PV_W-1:0]  eff;
  logic [OFF_W-1:0] off_cur;
  logic             hit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  hit_t             push_hit;
  hit_t             pop_hit;
  rep_state_t       state;
  rep_state_t       state_nxt;
  logic [PV_W-1:0]  work_vec;
  logic [PV_W-1:0]  work_rest;
  logic             unused_state;

  assign unused_state = ^in_state;

  assign eff      = (pkt_start ? {PV_W{1'b1}} : acc) & in_path;
  assign off_cur  = pkt_start ? '0 : offset;
  assign hit      = in_valid && in_final && (eff != '0);
  assign push_hit = '{pv: eff, off: off_cur};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '1;
      offset <= '0;
    end else if (in_valid) begin
      acc    <= eff;
      offset <= (off_cur == {OFF_W{1'b1}}) ? off_cur : off_cur + OFF_W'(1);
    end
  end

  // A hit arriving at a full queue is lost even if the queue pops this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_flag <= 1'b0;
      drop_cnt  <= '0;
    end else if (hit && fifo_full) begin
      drop_flag <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH(PV_W + OFF_W),
    .DEPTH(HIT_DEPTH)
  ) u_hit_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (hit),
    .wr_data(push_hit),
    .pop    (pop),
    .rd_data(pop_hit),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Vector with the currently reported (lowest) bit removed.
  assign work_rest = work_vec & (work_vec - PV_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (m.ready && work_rest == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event outputs are registered; the next rule index is precomputed so
  // nothing combinational reaches the channel from ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_vec <= '0;
      m.valid  <= 1'b0;
      m.rule   <= '0;
      m.offset <= '0;
    end else if (pop) begin
      work_vec <= pop_hit.pv;
      m.valid  <= 1'b1;
      m.rule   <= lowest_bit(pop_hit.pv);
      m.offset <= pop_hit.off;
    end else if (state == SCAN && m.ready) begin
      work_vec <= work_rest;
      if (work_rest == '0) m.valid <= 1'b0;
      else                 m.rule  <= lowest_bit(work_rest);
    end
  end
endmodule
